fork2_buffered: RTL and testbench
=================================

# fork2_buffered

Splits one valid/ready stream into two independent valid/ready streams, delivering every accepted input word exactly once to each branch, in order. Each branch has its own 2-entry buffer, so one slow consumer does not stall the other until that buffer fills. `data_in_ready` depends only on registered state, so there is no combinational path from either `data_out_*_ready` to `data_in_ready`. The block sits where one producer feeds two parallel datapaths that are later re-synchronised by a join.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `data_in` input `DATA_WIDTH`: upstream payload.
- `data_in_valid` input 1: upstream valid.
- `data_in_ready` output 1: upstream ready.
- `data_out_a` output `DATA_WIDTH`: branch A payload.
- `data_out_a_valid` output 1: branch A valid.
- `data_out_a_ready` input 1: branch A ready.
- `data_out_b` output `DATA_WIDTH`: branch B payload.
- `data_out_b_valid` output 1: branch B valid.
- `data_out_b_ready` input 1: branch B ready.

## Operation
- Each branch x (A or B) has:
  - 2-entry storage `mem_x[0:1]`;
  - 1-bit write pointer `wp_x` and 1-bit read pointer `rp_x`, which wrap 1→0;
  - 2-bit count `cnt_x` in {0, 1, 2}.
- Input handshake:
  - `data_in_ready = rst & (cnt_a != 2) & (cnt_b != 2)`.
  - `push = data_in_valid & data_in_ready`.
- On `push`: `data_in` is written to `mem_a[wp_a]` and `mem_b[wp_b]`, and both write pointers toggle.
- Branch x output:
  - `data_out_x_valid = (cnt_x != 0)`.
  - `data_out_x = mem_x[rp_x]`.
  - `pop_x = data_out_x_valid & data_out_x_ready`. On `pop_x`, `rp_x` toggles.
- Count update per branch:
  - push and no pop: +1.
  - pop and no push: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- A branch never underflows, because pop requires count ≠ 0.
- A branch never overflows, because push requires count ≠ 2.
- Branches drain independently, in any interleaving.
- A word is retired upstream at push. It is complete when both branches have popped it.
- A full branch (count 2) blocks input even if it is popping in that same cycle. This is intentional: it keeps ready registered-only, and costs one bubble.
- Valid protocol:
  - The upstream side must hold `data_in` stable while valid is high and ready is low.
  - The block holds `data_out_x` and `data_out_x_valid` stable until `pop_x`.
- Reset (`rst` low at a clock edge):
  - counts, pointers and `mem_*` are cleared to 0;
  - `data_in_ready` is 0 while `rst` is low;
  - all `data_out_*_valid` are 0 and `data_out_*` are 0 in the cycle after the reset edge.
- Reset while mid-operation discards all buffered words without emitting them.

## Timing
- Latency: a word pushed at edge t is visible with valid on both branches after edge t (cycle t+1).
- Throughput: 1 word/cycle sustained while both branches pop every cycle. In steady state each count stays at 1.
- Stall depth: with branch A stalled and B free-running, exactly 2 further words are accepted after A's last pop, then `data_in_ready` drops.
- Recovery: after a stalled branch pops from count 2, `data_in_ready` rises in the next cycle.
- First cycle after reset release: `data_in_ready` = 1 and both valids = 0.
- No combinational paths:
  - from `data_out_*_ready` to `data_in_ready`;
  - from `data_in_valid` to any output.

## Test plan
1. **Reset.** Hold `rst` = 0 for 3 cycles with `data_in_valid` = 1.
   - During reset: `data_in_ready` = 0, both valids = 0, both data = 0.
   - After release: `data_in_ready` = 1 on the first cycle.
2. **Streaming.** Both readies = 1; push 0x1..0x10 back to back.
   - Each word appears on A and B exactly one cycle after its push.
   - 16 words in 16 cycles, no bubbles.
3. **Branch A stalled.** `data_out_a_ready` = 0 and B ready = 1; offer 0xA0, 0xA1, 0xA2.
   - 0xA0 and 0xA1 are accepted and B outputs both.
   - `data_in_ready` = 0 with 0xA2 pending.
   - Then raise A ready: A outputs 0xA0, 0xA1, 0xA2 in order, and 0xA2 is accepted one cycle after A's first pop.
4. **Full branch popping, no same-cycle push.**
   - Setup: A at count 2 and B empty, with `data_out_a_ready` low and B ready high, after offering 2 words.
   - Pop A and offer a new word in the same cycle.
   - Required: no push in that cycle; A count = 1; push occurs the next cycle.
5. **Reset mid-operation.** Assert reset with A = 2 and B = 1 entries buffered.
   - After release: both valids = 0 and the previously buffered words never appear.
   - A subsequent 0x55 reaches both branches.
6. **Random backpressure.** Independent random readies at 30%, 70% and 100%, 10k words with random `data_in_valid`.
   - Each branch output sequence equals the input sequence exactly.
   - No count exceeds 2.
   - Outputs stay stable while valid is high and ready is low.

Source files
------------

// File: rtl/fork2_buffered.sv
// Purpose: fork one valid/ready stream into two branches, each with its own 2-entry buffer.
// Latency: a word accepted at edge t is valid on both branches in cycle t+1.
// Backpressure: data_in_ready drops only when a branch buffer holds 2 words; it is derived from registered counts only.
module fork2_buffered #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic                  data_out_a_valid,
  input  logic                  data_out_a_ready,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  data_out_b_valid,
  input  logic                  data_out_b_ready
);

  logic [DATA_WIDTH-1:0] mem_a [2];
  logic [DATA_WIDTH-1:0] mem_b [2];
  logic                  wp_a;
  logic                  rp_a;
  logic                  wp_b;
  logic                  rp_b;
  logic [1:0]            cnt_a;
  logic [1:0]            cnt_b;
  logic                  push;
  logic                  pop_a;
  logic                  pop_b;

  // A full branch blocks input even while it pops, so ready never sees a consumer ready.
  assign data_in_ready    = rst & (cnt_a != 2'd2) & (cnt_b != 2'd2);
  assign push             = data_in_valid & data_in_ready;

  assign data_out_a_valid = (cnt_a != 2'd0);
  assign data_out_a       = mem_a[rp_a];
  assign pop_a            = data_out_a_valid & data_out_a_ready;

  assign data_out_b_valid = (cnt_b != 2'd0);
  assign data_out_b       = mem_b[rp_b];
  assign pop_b            = data_out_b_valid & data_out_b_ready;

  // Branch A buffer: write on push, advance read on pop, track occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_a[0] <= '0;
      mem_a[1] <= '0;
      wp_a     <= 1'b0;
      rp_a     <= 1'b0;
      cnt_a    <= 2'd0;
    end else begin
      if (push) begin
        mem_a[wp_a] <= data_in;
        wp_a        <= ~wp_a;
      end
      if (pop_a) begin
        rp_a <= ~rp_a;
      end
      case ({push, pop_a})
        2'b10:   cnt_a <= cnt_a + 2'd1;
        2'b01:   cnt_a <= cnt_a - 2'd1;
        default: cnt_a <= cnt_a;
      endcase
    end
  end

  // Branch B buffer: same structure, drained independently of branch A.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_b[0] <= '0;
      mem_b[1] <= '0;
      wp_b     <= 1'b0;
      rp_b     <= 1'b0;
      cnt_b    <= 2'd0;
    end else begin
      if (push) begin
        mem_b[wp_b] <= data_in;
        wp_b        <= ~wp_b;
      end
      if (pop_b) begin
        rp_b <= ~rp_b;
      end
      case ({push, pop_b})
        2'b10:   cnt_b <= cnt_b + 2'd1;
        2'b01:   cnt_b <= cnt_b - 2'd1;
        default: cnt_b <= cnt_b;
      endcase
    end
  end

endmodule

// File: tb/tb_fork2_buffered.sv
// Purpose: self-checking bench for fork2_buffered with a queue scoreboard per branch.
// Latency: expects each accepted word on both branches one cycle after acceptance.
// Backpressure: exercises stalled, recovering and randomly throttled branches.
module tb_fork2_buffered;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [W-1:0] data_out_a;
  logic         data_out_a_valid;
  logic         data_out_a_ready;
  logic [W-1:0] data_out_b;
  logic         data_out_b_valid;
  logic         data_out_b_ready;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_a [$];
  logic [W-1:0] exp_b [$];
  bit           hold_a, hold_b;
  logic [W-1:0] held_a, held_b;
  bit           rand_mode = 1'b0;
  int unsigned  ra_pct, rb_pct;

  fork2_buffered #(.DATA_WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in          (data_in),
    .data_in_valid    (data_in_valid),
    .data_in_ready    (data_in_ready),
    .data_out_a       (data_out_a),
    .data_out_a_valid (data_out_a_valid),
    .data_out_a_ready (data_out_a_ready),
    .data_out_b       (data_out_b),
    .data_out_b_valid (data_out_b_valid),
    .data_out_b_ready (data_out_b_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; in random mode re-roll the branch readies.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      data_out_a_ready = ($urandom_range(99) < ra_pct);
      data_out_b_ready = ($urandom_range(99) < rb_pct);
    end
  endtask

  // Scoreboard monitor: records accepted words, checks every branch pop and output stability.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_a.delete();
        exp_b.delete();
        hold_a = 1'b0;
        hold_b = 1'b0;
      end else begin
        if (hold_a) begin
          chk1("a_stable_vld", data_out_a_valid, 1'b1);
          chk("a_stable_dat", data_out_a, held_a);
        end
        if (hold_b) begin
          chk1("b_stable_vld", data_out_b_valid, 1'b1);
          chk("b_stable_dat", data_out_b, held_b);
        end
        if (data_out_a_valid && data_out_a_ready) begin
          if (exp_a.size() == 0) chk1("a_unexpected_word", data_out_a_valid, 1'b0);
          else chk("a_data", data_out_a, exp_a.pop_front());
        end
        if (data_out_b_valid && data_out_b_ready) begin
          if (exp_b.size() == 0) chk1("b_unexpected_word", data_out_b_valid, 1'b0);
          else chk("b_data", data_out_b, exp_b.pop_front());
        end
        hold_a = data_out_a_valid && !data_out_a_ready;
        held_a = data_out_a;
        hold_b = data_out_b_valid && !data_out_b_ready;
        held_b = data_out_b;
        if (data_in_valid && data_in_ready) begin
          exp_a.push_back(data_in);
          exp_b.push_back(data_in);
          chk1("a_depth_le2", exp_a.size() <= 2, 1'b1);
          chk1("b_depth_le2", exp_b.size() <= 2, 1'b1);
        end
      end
    end
  endtask

  initial begin
    int unsigned ra_tab [3];
    int unsigned rb_tab [3];
    ra_tab = '{30, 70, 100};
    rb_tab = '{70, 100, 30};

    rst              = 1'b0;
    data_in          = 32'hDEAD_BEEF;
    data_in_valid    = 1'b1;
    data_out_a_ready = 1'b1;
    data_out_b_ready = 1'b1;

    fork
      monitor();
    join_none

    // Reset held for 3 cycles with valid asserted.
    for (int i = 0; i < 3; i++) begin
      cycle();
      @(negedge clk);
      chk1("rst_ready", data_in_ready, 1'b0);
      chk1("rst_a_vld", data_out_a_valid, 1'b0);
      chk1("rst_b_vld", data_out_b_valid, 1'b0);
      chk("rst_a_dat", data_out_a, 32'h0);
      chk("rst_b_dat", data_out_b, 32'h0);
    end
    cycle();
    rst           = 1'b1;
    data_in_valid = 1'b0;
    @(negedge clk);
    chk1("rel_ready", data_in_ready, 1'b1);
    chk1("rel_a_vld", data_out_a_valid, 1'b0);
    chk1("rel_b_vld", data_out_b_valid, 1'b0);

    // Streaming 0x1..0x10 with both branches ready.
    cycle();
    for (int i = 1; i <= 16; i++) begin
      data_in       = i;
      data_in_valid = 1'b1;
      @(negedge clk);
      chk1("stream_ready", data_in_ready, 1'b1);
      if (i > 1) begin
        chk("stream_lat_a", data_out_a, i - 1);
        chk("stream_lat_b", data_out_b, i - 1);
      end
      cycle();
    end
    data_in_valid = 1'b0;
    @(negedge clk);
    chk1("stream_last_a_vld", data_out_a_valid, 1'b1);
    chk("stream_last_a", data_out_a, 32'h10);
    chk("stream_last_b", data_out_b, 32'h10);
    cycle();

    // Branch A stalled.
    data_out_a_ready = 1'b0;
    data_in          = 32'hA0;
    data_in_valid    = 1'b1;
    @(negedge clk);
    chk1("stallA_rdy0", data_in_ready, 1'b1);
    cycle();
    data_in = 32'hA1;
    @(negedge clk);
    chk1("stallA_rdy1", data_in_ready, 1'b1);
    chk("stallA_b0", data_out_b, 32'hA0);
    cycle();
    data_in = 32'hA2;
    @(negedge clk);
    chk1("stallA_rdy2_low", data_in_ready, 1'b0);
    chk("stallA_b1", data_out_b, 32'hA1);
    chk("stallA_a_head", data_out_a, 32'hA0);
    cycle();
    @(negedge clk);
    chk1("stallA_still_low", data_in_ready, 1'b0);
    chk1("stallA_b_empty", data_out_b_valid, 1'b0);
    cycle();
    data_out_a_ready = 1'b1;
    @(negedge clk);
    chk1("stallA_full_pop_blocks", data_in_ready, 1'b0);
    chk("stallA_a0", data_out_a, 32'hA0);
    cycle();
    @(negedge clk);
    chk1("stallA_recover", data_in_ready, 1'b1);
    chk("stallA_a1", data_out_a, 32'hA1);
    cycle();
    data_in_valid = 1'b0;
    @(negedge clk);
    chk("stallA_a2", data_out_a, 32'hA2);
    chk("stallA_b2", data_out_b, 32'hA2);
    cycle();
    @(negedge clk);
    chk1("stallA_drained", data_out_a_valid, 1'b0);

    // Full branch popping: no same-cycle push.
    cycle();
    data_out_a_ready = 1'b0;
    data_in          = 32'h40;
    data_in_valid    = 1'b1;
    cycle();
    data_in = 32'h41;
    cycle();
    data_in_valid = 1'b0;
    cycle();
    @(negedge clk);
    chk1("full_setup_rdy", data_in_ready, 1'b0);
    chk1("full_setup_b_empty", data_out_b_valid, 1'b0);
    cycle();
    data_out_a_ready = 1'b1;
    data_in          = 32'h42;
    data_in_valid    = 1'b1;
    @(negedge clk);
    chk1("full_pop_no_push", data_in_ready, 1'b0);
    chk("full_pop_a_head", data_out_a, 32'h40);
    cycle();
    @(negedge clk);
    chk1("full_next_push", data_in_ready, 1'b1);
    chk1("full_b_no_word", data_out_b_valid, 1'b0);
    chk("full_a_second", data_out_a, 32'h41);
    cycle();
    data_in_valid = 1'b0;
    @(negedge clk);
    chk("full_a_new", data_out_a, 32'h42);
    chk("full_b_new", data_out_b, 32'h42);
    cycle();

    // Reset mid-operation with A=2 and B=1 buffered.
    data_out_a_ready = 1'b0;
    data_out_b_ready = 1'b1;
    data_in          = 32'h50;
    data_in_valid    = 1'b1;
    cycle();
    data_in = 32'h51;
    cycle();
    data_in_valid    = 1'b0;
    data_out_b_ready = 1'b0;
    rst              = 1'b0;
    @(negedge clk);
    chk1("midrst_ready", data_in_ready, 1'b0);
    chk1("midrst_b_has1", data_out_b_valid, 1'b1);
    cycle();
    rst              = 1'b1;
    data_out_a_ready = 1'b1;
    data_out_b_ready = 1'b1;
    @(negedge clk);
    chk1("midrst_a_vld", data_out_a_valid, 1'b0);
    chk1("midrst_b_vld", data_out_b_valid, 1'b0);
    chk1("midrst_ready1", data_in_ready, 1'b1);
    cycle();
    data_in       = 32'h55;
    data_in_valid = 1'b1;
    @(negedge clk);
    chk1("post_rst_ready", data_in_ready, 1'b1);
    cycle();
    data_in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_a", data_out_a, 32'h55);
    chk("post_rst_b", data_out_b, 32'h55);
    cycle();

    // Random backpressure, 10k words across three ready mixes.
    for (int p = 0; p < 3; p++) begin
      int sent;
      int idle;
      bit acc;
      ra_pct    = ra_tab[p];
      rb_pct    = rb_tab[p];
      rand_mode = 1'b1;
      sent      = 0;
      idle      = 0;
      while (sent < ((p == 2) ? 3332 : 3334)) begin
        if (!data_in_valid) begin
          data_in_valid = ($urandom_range(99) < 70);
          data_in       = $urandom;
        end
        @(negedge clk);
        acc = data_in_valid && data_in_ready;
        if (acc) begin
          sent++;
          idle = 0;
        end else begin
          idle++;
        end
        cycle();
        if (acc) data_in_valid = 1'b0;
        if (idle > 300) begin
          chk1("rand_progress", 1'b0, 1'b1);
          break;
        end
      end
    end
    rand_mode        = 1'b0;
    data_in_valid    = 1'b0;
    data_out_a_ready = 1'b1;
    data_out_b_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    @(negedge clk);
    chk("drain_a_empty", exp_a.size(), 32'd0);
    chk("drain_b_empty", exp_b.size(), 32'd0);
    chk1("drain_a_vld", data_out_a_valid, 1'b0);
    chk1("drain_b_vld", data_out_b_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
